// File: rtl/uart_phy.sv
// -----------------------------------------------------------------------------
// uart_phy
//
// Full-duplex 8N1 UART physical layer: one transmitter and one receiver that
// share a single baud configuration. Frames are 1 start bit (0), 8 data bits
// LSB first, 1 stop bit (1), no parity.
//
// Parameters
//    CLK_FREQ      system clock frequency in Hz
//    BAUD          serial bit rate
//    CLKS_PER_BIT  clock cycles per bit period (minimum 4)
//
// Ports
//    clk       system clock, rising edge
//    reset     asynchronous, active-low reset
//    tx_dv     transmit request, only honoured while the transmitter is idle
//    tx_byte   byte to send, captured together with an accepted tx_dv
//    tx        serial output, idles high
//    tx_busy   high while a transmit frame is in progress
//    rx        serial input, asynchronous to clk
//    rx_dv     one-cycle strobe marking a valid received byte
//    rx_byte   last valid received byte, held until the next valid frame
//
// Build option
//    UART_RX_SYNC_EN  when defined, rx passes through a 2-flop synchroniser
//                     (reset to 1) before the receiver; when undefined, rx
//                     feeds the receiver directly (simulation use only).
// -----------------------------------------------------------------------------
module uart_phy #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_dv,
   input  logic [7:0] tx_byte,
   output logic       tx,
   output logic       tx_busy,
   input  logic       rx,
   output logic       rx_dv,
   output logic [7:0] rx_byte
);

   // Bit-period counter must hold CLKS_PER_BIT-1.
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   // Terminal counts: full bit period, and the half-bit point used to
   // re-check the start bit at its centre.
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

   // Shared state encoding for both FSMs.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // --------------------------------------------------------------------------
   // Transmitter
   // --------------------------------------------------------------------------
   logic [1:0]       tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
   logic [2:0]       tx_idx_q,   tx_idx_d;
   logic [7:0]       tx_data_q,  tx_data_d;
   logic             tx_q,       tx_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_data_d  = tx_data_q;
      tx_d       = tx_q;

      case (tx_state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (tx_dv) begin
               // Line goes low in the same update that enters START, so the
               // start bit occupies exactly CLKS_PER_BIT cycles.
               tx_data_d  = tx_byte;
               tx_cnt_d   = CNT_ZERO;
               tx_idx_d   = 3'd0;
               tx_state_d = ST_START;
               tx_d       = 1'b0;
            end
         end

         ST_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = CNT_ZERO;
               tx_idx_d   = 3'd0;
               tx_state_d = ST_DATA;
               tx_d       = tx_data_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = CNT_ZERO;
               if (tx_idx_q == 3'd7) begin
                  tx_state_d = ST_STOP;
                  tx_d       = 1'b1;
               end else begin
                  tx_idx_d = tx_idx_q + 3'd1;
                  tx_d     = tx_data_q[tx_idx_q + 3'd1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end

         default: begin // ST_STOP
            tx_d = 1'b1;
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = CNT_ZERO;
               tx_state_d = ST_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // tx_q resets to 1 asynchronously, so a reset mid-frame releases the line
   // immediately rather than on the next clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= 3'd0;
         tx_data_q  <= 8'h00;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_data_q  <= tx_data_d;
         tx_q       <= tx_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = (tx_state_q != ST_IDLE);

   // --------------------------------------------------------------------------
   // Receive input conditioning
   // --------------------------------------------------------------------------
   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] rx_sync_q, rx_sync_d;

   always_comb begin
      rx_sync_d = {rx_sync_q[0], rx};
   end

   // Reset to the idle-line level so leaving reset never looks like a start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_sync_q <= 2'b11;
      end else begin
         rx_sync_q <= rx_sync_d;
      end
   end

   assign rx_s = rx_sync_q[1];
`else
   assign rx_s = rx;
`endif

   // --------------------------------------------------------------------------
   // Receiver
   // --------------------------------------------------------------------------
   logic [1:0]       rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
   logic [2:0]       rx_idx_q,   rx_idx_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic [7:0]       rx_byte_q,  rx_byte_d;
   logic             rx_dv_q,    rx_dv_d;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_byte_d  = rx_byte_q;
      rx_dv_d    = 1'b0;

      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = CNT_ZERO;
            if (!rx_s) begin
               rx_state_d = ST_START;
            end
         end

         ST_START: begin
            // Re-check at mid start bit: a line that is high again was a
            // glitch, not a frame.
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = CNT_ZERO;
               if (!rx_s) begin
                  rx_idx_d   = 3'd0;
                  rx_state_d = ST_DATA;
               end else begin
                  rx_state_d = ST_IDLE;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end

         ST_DATA: begin
            // Counting a full period from the start-bit centre lands each
            // sample at a data-bit centre.
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = CNT_ZERO;
               rx_shift_d = {rx_s, rx_shift_q[7:1]};
               if (rx_idx_q == 3'd7) begin
                  rx_state_d = ST_STOP;
               end else begin
                  rx_idx_d = rx_idx_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end

         default: begin // ST_STOP
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = CNT_ZERO;
               rx_state_d = ST_IDLE;
               // A low stop bit is a framing error: the byte is discarded and
               // the previously published byte stays visible.
               if (rx_s) begin
                  rx_byte_d = rx_shift_q;
                  rx_dv_d   = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_byte_q  <= 8'h00;
         rx_dv_q    <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         rx_dv_q    <= rx_dv_d;
      end
   end

   assign rx_dv   = rx_dv_q;
   assign rx_byte = rx_byte_q;

endmodule

// File: tb/tb_uart_phy.sv
// -----------------------------------------------------------------------------
// tb_uart_phy
//
// Self-checking bench for uart_phy. The expected serial waveform is derived
// from the frame rule (start 0, data LSB first, stop 1) sampled at bit centres;
// received bytes are collected by a monitor into a queue and matched against
// what was sent. A short CLKS_PER_BIT keeps the run brief.
// -----------------------------------------------------------------------------
module tb_uart_phy;

   localparam int CPB = 16;

   logic       clk     = 1'b0;
   logic       reset   = 1'b0;
   logic       tx_dv   = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       tx;
   logic       tx_busy;
   logic       rx;
   logic       rx_dv;
   logic [7:0] rx_byte;

   // rx is either the looped-back tx or a line driven directly by the bench.
   logic loop_en = 1'b1;
   logic rx_drv  = 1'b1;
   assign rx = loop_en ? tx : rx_drv;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int accept_cyc = 0;

   logic [7:0] rx_q[$];
   int         rx_t[$];

   uart_phy #(
      .CLK_FREQ    (100_000_000),
      .BAUD        (115200),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .tx_dv  (tx_dv),
      .tx_byte(tx_byte),
      .tx     (tx),
      .tx_busy(tx_busy),
      .rx     (rx),
      .rx_dv  (rx_dv),
      .rx_byte(rx_byte)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every rx_dv strobe is recorded with its cycle stamp.
   always @(negedge clk) begin
      if (rx_dv) begin
         rx_q.push_back(rx_byte);
         rx_t.push_back(cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Line level of frame bit k (0 = start, 1..8 = data LSB first, 9 = stop).
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   // Called at a negedge with the transmitter idle. Optionally pulses a second
   // request mid-frame, which must be ignored. Returns at the first negedge
   // where tx_busy is low again.
   task automatic send(input logic [7:0] b, input bit mid_dv, input logic [7:0] b2);
      int c;
      int busy_cnt;
      check("tx_idle_at_req", tx_busy, 1'b0);
      tx_dv   = 1'b1;
      tx_byte = b;
      @(negedge clk);
      accept_cyc = cyc;
      tx_dv    = 1'b0;
      c        = 0;
      busy_cnt = 0;
      while (tx_busy && c < 12*CPB) begin
         if (c % CPB == CPB/2)
            check($sformatf("tx_bit%0d", c / CPB), tx, frame_bit(b, c / CPB));
         if (mid_dv && c == 3*CPB) begin
            tx_dv   = 1'b1;
            tx_byte = b2;
         end else begin
            tx_dv = 1'b0;
         end
         busy_cnt++;
         c++;
         @(negedge clk);
      end
      tx_dv = 1'b0;
      check("tx_busy_len", busy_cnt, 10*CPB);
      check("tx_high_after", tx, 1'b1);
      $display("send 0x%02h", b);
   endtask

   task automatic expect_rx(input logic [7:0] b);
      int lat;
      logic [7:0] d;
      while (rx_q.size() == 0 && (cyc - accept_cyc) < 24*CPB) @(negedge clk);
      check("rx_seen", rx_q.size() != 0, 1'b1);
      if (rx_q.size() != 0) begin
         d   = rx_q.pop_front();
         lat = rx_t.pop_front() - accept_cyc;
         check("rx_data", d, b);
         check("rx_latency", (lat > 0) && (lat < 10*CPB), 1'b1);
         check("rx_byte_hold", rx_byte, b);
         $display("recv 0x%02h latency %0d", d, lat);
      end
   endtask

   task automatic expect_quiet(input int cycles, input string tag);
      repeat (cycles) @(negedge clk);
      check(tag, rx_q.size(), 0);
   endtask

   // Bench-driven frame on rx with a selectable stop-bit level.
   task automatic drive_frame(input logic [7:0] b, input logic stop);
      loop_en    = 1'b0;
      accept_cyc = cyc;
      for (int k = 0; k < 10; k++) begin
         rx_drv = (k == 9) ? stop : frame_bit(b, k);
         repeat (CPB) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   initial begin
      logic [7:0] dir_bytes [4];
      logic [7:0] rb;
      dir_bytes = '{8'h55, 8'hAA, 8'h30, 8'h39};

      // Reset values while held in reset.
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_tx_busy", tx_busy, 1'b0);
      check("rst_rx_dv", rx_dv, 1'b0);
      check("rst_rx_byte", rx_byte, 8'h00);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_tx", tx, 1'b1);

      // Directed loopback bytes.
      for (int i = 0; i < 4; i++) begin
         send(dir_bytes[i], 1'b0, 8'h00);
         expect_rx(dir_bytes[i]);
      end

      // Request during a frame is ignored.
      send(8'hA5, 1'b1, 8'h12);
      expect_rx(8'hA5);
      expect_quiet(12*CPB, "no_rx_for_ignored_req");

      // Short low glitch is rejected as a false start.
      loop_en = 1'b0;
      rx_drv  = 1'b0;
      repeat (CPB/4) @(negedge clk);
      rx_drv = 1'b1;
      expect_quiet(3*CPB, "glitch_no_rx_dv");
      check("glitch_rx_byte", rx_byte, 8'hA5);

      // Framing error drops the byte; a good frame afterwards is received.
      drive_frame(8'h3C, 1'b0);
      expect_quiet(3*CPB, "frame_err_no_rx_dv");
      check("frame_err_rx_byte", rx_byte, 8'hA5);
      drive_frame(8'h3C, 1'b1);
      expect_rx(8'h3C);
      loop_en = 1'b1;
      repeat (2) @(negedge clk);

      // Random loopback bytes.
      for (int i = 0; i < 8; i++) begin
         rb = 8'($urandom);
         send(rb, 1'b0, 8'h00);
         expect_rx(rb);
      end

      // Reset in the middle of the data bits.
      tx_dv   = 1'b1;
      tx_byte = 8'h5A;
      @(negedge clk);
      tx_dv = 1'b0;
      repeat (5*CPB) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_tx", tx, 1'b1);
      check("midrst_tx_busy", tx_busy, 1'b0);
      check("midrst_rx_dv", rx_dv, 1'b0);
      check("midrst_rx_byte", rx_byte, 8'h00);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      expect_quiet(12*CPB, "midrst_no_rx_dv");
      send(8'hFF, 1'b0, 8'h00);
      expect_rx(8'hFF);

      // Back-to-back requests in the first idle cycle.
      send(8'h00, 1'b0, 8'h00);
      expect_rx(8'h00);
      send(8'hFF, 1'b0, 8'h00);
      expect_rx(8'hFF);

      expect_quiet(12*CPB, "final_no_extra_rx");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_phy.md
# uart_phy

Full-duplex 8N1 UART physical layer with one transmitter and one receiver sharing a baud configuration. It sits between the board serial pins and the byte-level host/command logic. The TX half serialises one byte per `tx_dv` pulse. The RX half deserialises incoming frames and emits one-cycle `rx_dv` strobes. With `tx` looped to `rx`, every transmitted byte must be received unchanged.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: serial bit rate.
- `CLKS_PER_BIT`, default `CLK_FREQ/BAUD` (868): clock cycles per bit period. Minimum legal value is 4.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset (asserted when 0).
- `tx_dv`, input, 1: transmit request. Sampled when TX is idle.
- `tx_byte`, input, 8: byte to send. Captured in the same cycle as an accepted `tx_dv`.
- `tx`, output, 1: serial output. Idles high.
- `tx_busy`, output, 1: high while a frame is in progress.
- `rx`, input, 1: serial input. Asynchronous to `clk`.
- `rx_dv`, output, 1: one-cycle strobe indicating a valid received byte.
- `rx_byte`, output, 8: last valid received byte.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX FSM states: IDLE, START, DATA, STOP.
  - In IDLE, if `tx_dv`=1, latch `tx_byte` and go to START.
  - START drives 0 for `CLKS_PER_BIT` cycles.
  - DATA drives bit i for `CLKS_PER_BIT` cycles, for i=0..7, using a 3-bit index.
  - STOP drives 1 for `CLKS_PER_BIT` cycles, then returns to IDLE.
  - `tx_dv` is ignored in every state other than IDLE. There is no queueing.
- RX FSM states: IDLE, START, DATA, STOP.
  - In IDLE, a low level on the (synchronised) `rx` moves the FSM to START.
  - START: at the half-bit point (`CLKS_PER_BIT/2` cycles), re-sample `rx`. If it is low, restart the bit counter and go to DATA. If it is high, treat it as a false start and return to IDLE.
  - DATA: sample every `CLKS_PER_BIT` cycles, at bit centres, shifting LSB first. After 8 samples go to STOP.
  - STOP: sample one bit period later.
    - If the sample is 1, load `rx_byte` and pulse `rx_dv` for exactly one cycle.
    - If the sample is 0 (framing error), drop the byte. `rx_dv` stays low and `rx_byte` is unchanged.
    - In both cases return to IDLE.
- `rx_byte` holds its value until the next valid frame.
- TX and RX are fully independent and may operate simultaneously.
- Reset value of every output: `tx`=1, `tx_busy`=0, `rx_dv`=0, `rx_byte`=0x00. Both FSMs reset to IDLE and all counters reset to 0.
- Reset mid-frame aborts the frame immediately. `tx` returns high asynchronously, and no `rx_dv` is produced for the partial frame.

## Timing
- TX:
  - A `tx_dv` accepted at edge N drives `tx` low from edge N+1.
  - `tx_busy` is high from edge N+1 through the last stop-bit cycle.
  - The frame lasts exactly `10*CLKS_PER_BIT` cycles.
  - After `tx_busy` falls, `tx_dv` may be asserted in the very next cycle. Back-to-back frames have no idle gap.
- RX:
  - `rx_dv` rises about 9.5 bit periods after the falling start edge, plus synchroniser delay.
  - `rx_byte` is valid in the same cycle as `rx_dv`.
- Loopback latency from the `tx_dv` edge to `rx_dv` is below `10*CLKS_PER_BIT` cycles, about 8250 cycles at the defaults. It must never exceed `24*CLKS_PER_BIT`.
- Counters must be wide enough for `CLKS_PER_BIT-1`, using `$clog2`.

## Configuration
- `UART_RX_SYNC_EN`:
  - When defined, `rx` passes through a 2-flop synchroniser, reset to 1, before the RX FSM. This adds 2 cycles of RX latency.
  - When undefined, `rx` feeds the FSM directly, for simulation only. Functional results are identical.

## Test plan
- Loopback, reset released, defaults: send 0x55, 0xAA, 0x30 ('0'), 0x39 ('9'), each as a single-cycle `tx_dv`. Required: exactly one `rx_dv` per byte, with `rx_byte` equal to the byte sent, within `24*CLKS_PER_BIT` cycles.
- Pulse `tx_dv` with 0x12 mid-frame while sending 0xA5. Required: only 0xA5 is received, `tx_busy` stays high for exactly `10*CLKS_PER_BIT` cycles, and `tx` is high afterwards.
- Drive a low glitch of `CLKS_PER_BIT/4` cycles on `rx`. Required: no `rx_dv`, `rx_byte` unchanged, RX back in IDLE.
- Drive a frame carrying 0x3C with the stop bit forced to 0. Required: no `rx_dv` and `rx_byte` keeps its previous value. A following good 0x3C frame is received correctly.
- Assert `reset`=0 halfway through the data bits of a frame. Required: `tx`=1, `tx_busy`=0, `rx_dv`=0 immediately. After release, 0xFF loops back correctly.
- Issue `tx_dv` for 0x00 then 0xFF in the first cycle that `tx_busy` is low after the first frame. Required: both bytes are received in order, with no stuck state.
